uart_broadcast_scheduler: RTL and testbench

Sequences the inverter's normal-mode sample flow. Once per modulation period it requests a sample from the SPI front end and latches `sin_index`/`uart_id`. It then broadcasts that sample as two bytes to all module UART transmitters, handshaking on every `tx_busy` line rather than module 0 only, and finally emits the `shoot` pulse. It replaces the inline normal-mode FSM in the top level and sits between `SPI_request_data` and the `uart_tx` array.

---
 rtl/uart_broadcast_scheduler.sv | 172 +++++++++++++++++
 tb/tb_uart_broadcast_scheduler.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_broadcast_scheduler.sv
// uart_broadcast_scheduler: normal-mode sample sequencer.
// Once per period: request an SPI sample, broadcast it as two bytes to every
// UART transmitter (handshaking on all busy lines), then fire the shoot pulse.
module uart_broadcast_scheduler #(
  parameter int NUM_MODULES = 9,
  parameter int PERIOD      = 2400,
  parameter int SHOOT_WIDTH = 4,
  parameter int TIMEOUT     = 4096
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  output logic                       spi_start,
  input  logic                       spi_valid,
  input  logic [11:0]                sin_index,
  input  logic [3:0]                 uart_id,
  output logic [NUM_MODULES-1:0]     start_tx,
  output logic [8*NUM_MODULES-1:0]   data_to_tx,
  input  logic [NUM_MODULES-1:0]     tx_busy,
  output logic                       shoot,
  output logic                       frame_done,
  output logic                       overrun,
  output logic                       timeout_err
);

  localparam int PW = $clog2(PERIOD);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(SHOOT_WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE, REQ, SEND_HI, WAIT_HI, SEND_LO, WAIT_LO, SHOOT
  } state_t;

  state_t        state;
  logic [PW-1:0] pcnt;
  logic [TW-1:0] tcnt;
  logic [SW-1:0] scnt;
  // Only the low sample byte is kept: the high byte goes straight from the
  // SPI inputs into the data lanes on the same edge it is latched.
  logic [7:0]    smp_lo;
  logic          tick;
  logic          t_expired;

  // Period tick and handshake-timeout detection.
  always_comb begin
    tick      = enable && (pcnt == PW'(PERIOD - 1));
    t_expired = (tcnt == TW'(TIMEOUT - 1));
  end

  // Free-running period counter, parked at zero while disabled.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pcnt <= '0;
    end else if (!enable || tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  // Frame sequencer with registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      tcnt        <= '0;
      scnt        <= '0;
      smp_lo      <= '0;
      spi_start   <= 1'b0;
      start_tx    <= '0;
      data_to_tx  <= '0;
      shoot       <= 1'b0;
      frame_done  <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (tick && (state != IDLE)) begin
        overrun <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (tick) begin
            spi_start <= 1'b1;
            tcnt      <= '0;
            state     <= REQ;
          end
        end

        REQ: begin
          if (t_expired) begin
            timeout_err <= 1'b1;
            spi_start   <= 1'b0;
            start_tx    <= '0;
            state       <= IDLE;
          end else if (spi_valid) begin
            smp_lo     <= {sin_index[3:0], uart_id};
            spi_start  <= 1'b0;
            start_tx   <= '1;
            data_to_tx <= {NUM_MODULES{sin_index[11:4]}};
            tcnt       <= '0;
            state      <= SEND_HI;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end

        SEND_HI, SEND_LO: begin
          if (t_expired) begin
            timeout_err <= 1'b1;
            spi_start   <= 1'b0;
            start_tx    <= '0;
            state       <= IDLE;
          end else if (&tx_busy) begin
            start_tx <= '0;
            tcnt     <= '0;
            state    <= (state == SEND_HI) ? WAIT_HI : WAIT_LO;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end

        WAIT_HI: begin
          if (t_expired) begin
            timeout_err <= 1'b1;
            spi_start   <= 1'b0;
            start_tx    <= '0;
            state       <= IDLE;
          end else if (!(|tx_busy)) begin
            start_tx   <= '1;
            data_to_tx <= {NUM_MODULES{smp_lo}};
            tcnt       <= '0;
            state      <= SEND_LO;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end

        WAIT_LO: begin
          if (t_expired) begin
            timeout_err <= 1'b1;
            spi_start   <= 1'b0;
            start_tx    <= '0;
            state       <= IDLE;
          end else if (!(|tx_busy)) begin
            shoot      <= 1'b1;
            scnt       <= '0;
            frame_done <= (SHOOT_WIDTH == 1);
            state      <= SHOOT;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end

        SHOOT: begin
          // frame_done is registered, so it is raised one edge early to
          // coincide with the final shoot cycle.
          if (int'(scnt) == SHOOT_WIDTH - 1) begin
            shoot <= 1'b0;
            state <= IDLE;
          end else begin
            scnt       <= scnt + 1'b1;
            frame_done <= (int'(scnt) == SHOOT_WIDTH - 2);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_broadcast_scheduler.sv
// Directed bench for uart_broadcast_scheduler with SPI and UART behavioural
// models. Instance 0: PERIOD=32, TIMEOUT=64. Instance 1: PERIOD=16.
module tb_uart_broadcast_scheduler;

  localparam int NM = 9;
  localparam int HL = 256;

  logic clk = 1'b0;
  logic reset;
  logic enable;

  logic [1:0]             spi_start;
  logic [1:0]             spi_valid;
  logic [1:0][11:0]       sin_index;
  logic [1:0][3:0]        uart_id;
  logic [1:0][NM-1:0]     start_tx;
  logic [1:0][8*NM-1:0]   data_to_tx;
  logic [1:0][NM-1:0]     tx_busy;
  logic [1:0]             shoot;
  logic [1:0]             frame_done;
  logic [1:0]             overrun;
  logic [1:0]             timeout_err;

  always #5 clk = ~clk;

  uart_broadcast_scheduler #(
    .NUM_MODULES(NM), .PERIOD(32), .SHOOT_WIDTH(4), .TIMEOUT(64)
  ) u_dut (
    .clk(clk), .reset(reset), .enable(enable),
    .spi_start(spi_start[0]), .spi_valid(spi_valid[0]),
    .sin_index(sin_index[0]), .uart_id(uart_id[0]),
    .start_tx(start_tx[0]), .data_to_tx(data_to_tx[0]), .tx_busy(tx_busy[0]),
    .shoot(shoot[0]), .frame_done(frame_done[0]),
    .overrun(overrun[0]), .timeout_err(timeout_err[0])
  );

  uart_broadcast_scheduler #(
    .NUM_MODULES(NM), .PERIOD(16), .SHOOT_WIDTH(4), .TIMEOUT(64)
  ) u_dut16 (
    .clk(clk), .reset(reset), .enable(enable),
    .spi_start(spi_start[1]), .spi_valid(spi_valid[1]),
    .sin_index(sin_index[1]), .uart_id(uart_id[1]),
    .start_tx(start_tx[1]), .data_to_tx(data_to_tx[1]), .tx_busy(tx_busy[1]),
    .shoot(shoot[1]), .frame_done(frame_done[1]),
    .overrun(overrun[1]), .timeout_err(timeout_err[1])
  );

  // Model configuration (spi_lat 0 = SPI never answers)
  int spi_lat [2];
  int dly     [2][NM];
  int hold    [2][NM];

  // Model state
  int spi_cnt [2];
  int dcnt    [2][NM];
  int bcnt    [2][NM];
  bit armed   [2][NM];

  // SPI and UART models, updated on the falling edge
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset) begin
        spi_cnt[i]   = 0;
        spi_valid[i] = 1'b0;
        tx_busy[i]   = '0;
        for (int k = 0; k < NM; k++) begin
          dcnt[i][k]  = 0;
          bcnt[i][k]  = 0;
          armed[i][k] = 1'b0;
        end
      end else begin
        spi_valid[i] = 1'b0;
        if (spi_start[i] && spi_lat[i] != 0) begin
          spi_cnt[i]++;
          if (spi_cnt[i] == spi_lat[i]) spi_valid[i] = 1'b1;
        end else begin
          spi_cnt[i] = 0;
        end
        for (int k = 0; k < NM; k++) begin
          if (!start_tx[i][k]) armed[i][k] = 1'b0;
          if (bcnt[i][k] > 0) begin
            bcnt[i][k]--;
            if (bcnt[i][k] == 0) tx_busy[i][k] = 1'b0;
          end else if (dcnt[i][k] > 0) begin
            dcnt[i][k]--;
            if (dcnt[i][k] == 0) begin
              tx_busy[i][k] = 1'b1;
              bcnt[i][k]    = hold[i][k];
            end
          end else if (start_tx[i][k] && !armed[i][k]) begin
            armed[i][k] = 1'b1;
            dcnt[i][k]  = dly[i][k];
          end
        end
      end
    end
  end

  // Per-cycle history, index = rising edges since enable went high
  int                 cyc;
  logic               r_sp [2][HL];
  logic [NM-1:0]      r_st [2][HL];
  logic [8*NM-1:0]    r_dt [2][HL];
  logic               r_sh [2][HL];
  logic               r_fd [2][HL];
  logic               r_ov [2][HL];
  logic               r_te [2][HL];

  int n_cmp = 0;
  int n_err = 0;

  logic [71:0] lanes_ab;
  logic [71:0] lanes_c5;

  task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
    cyc++;
    if (cyc >= 0 && cyc < HL) begin
      for (int i = 0; i < 2; i++) begin
        r_sp[i][cyc] = spi_start[i];
        r_st[i][cyc] = start_tx[i];
        r_dt[i][cyc] = data_to_tx[i];
        r_sh[i][cyc] = shoot[i];
        r_fd[i][cyc] = frame_done[i];
        r_ov[i][cyc] = overrun[i];
        r_te[i][cyc] = timeout_err[i];
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  function automatic int cnt_sh(input int i, input int lo, input int hi);
    int c = 0;
    for (int n = lo; n <= hi; n++) c += (r_sh[i][n] === 1'b1) ? 1 : 0;
    return c;
  endfunction

  function automatic int cnt_fd(input int i, input int lo, input int hi);
    int c = 0;
    for (int n = lo; n <= hi; n++) c += (r_fd[i][n] === 1'b1) ? 1 : 0;
    return c;
  endfunction

  function automatic int cnt_sp(input int i, input int lo, input int hi);
    int c = 0;
    for (int n = lo; n <= hi; n++) c += (r_sp[i][n] === 1'b1) ? 1 : 0;
    return c;
  endfunction

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_spi_start"},  72'(spi_start[0]),   72'd0);
    check_eq({tag, "_start_tx"},   72'(start_tx[0]),    72'd0);
    check_eq({tag, "_data"},       72'(data_to_tx[0]),  72'd0);
    check_eq({tag, "_shoot"},      72'(shoot[0]),       72'd0);
    check_eq({tag, "_frame_done"}, 72'(frame_done[0]),  72'd0);
    check_eq({tag, "_overrun"},    72'(overrun[0]),     72'd0);
    check_eq({tag, "_timeout"},    72'(timeout_err[0]), 72'd0);
  endtask

  task automatic do_reset(input string tag);
    reset  = 1'b0;
    enable = 1'b0;
    step();
    step();
    check_zero_outputs(tag);
  endtask

  task automatic start_run();
    reset  = 1'b1;
    enable = 1'b1;
    cyc    = 0;
  endtask

  task automatic default_cfg();
    for (int i = 0; i < 2; i++) begin
      spi_lat[i] = 3;
      for (int k = 0; k < NM; k++) begin
        dly[i][k]  = 1;
        hold[i][k] = (i == 0) ? 10 : 20;
      end
    end
  endtask

  initial begin
    reset     = 1'b0;
    enable    = 1'b0;
    cyc       = 0;
    lanes_ab  = {9{8'hAB}};
    lanes_c5  = {9{8'hC5}};
    for (int i = 0; i < 2; i++) begin
      sin_index[i] = 12'hABC;
      uart_id[i]   = 4'h5;
    end
    default_cfg();

    // 1: basic frame
    do_reset("t1_rst");
    start_run();
    run(70);
    check_eq("t1_spi_pre",    72'(r_sp[0][31]), 72'd0);
    check_eq("t1_spi_start",  72'(r_sp[0][32]), 72'd1);
    check_eq("t1_spi_drop",   72'(r_sp[0][35]), 72'd0);
    check_eq("t1_start_hi",   72'(r_st[0][35]), 72'h1FF);
    check_eq("t1_data_hi",    r_dt[0][35],      lanes_ab);
    check_eq("t1_start_held", 72'(r_st[0][36]), 72'h1FF);
    check_eq("t1_start_fall", 72'(r_st[0][37]), 72'd0);
    check_eq("t1_data_hold",  r_dt[0][46],      lanes_ab);
    check_eq("t1_start_lo",   72'(r_st[0][47]), 72'h1FF);
    check_eq("t1_data_lo",    r_dt[0][47],      lanes_c5);
    check_eq("t1_start_fall2",72'(r_st[0][49]), 72'd0);
    check_eq("t1_shoot_pre",  72'(r_sh[0][58]), 72'd0);
    check_eq("t1_shoot_rise", 72'(r_sh[0][59]), 72'd1);
    check_eq("t1_shoot_len",  72'(cnt_sh(0, 1, 63)), 72'd4);
    check_eq("t1_fd_count",   72'(cnt_fd(0, 1, 63)), 72'd1);
    check_eq("t1_fd_last",    72'(r_fd[0][62]), 72'd1);
    check_eq("t1_no_overrun", 72'(r_ov[0][63]), 72'd0);

    // 2: module 8 goes busy 3 cycles later and clears 5 cycles later
    do_reset("t2_rst");
    dly[0][8]  = 4;
    hold[0][8] = 12;
    start_run();
    run(75);
    check_eq("t2_start_hold", 72'(r_st[0][39]), 72'h1FF);
    check_eq("t2_start_fall", 72'(r_st[0][40]), 72'd0);
    check_eq("t2_lo_wait",    72'(r_st[0][51]), 72'd0);
    check_eq("t2_lo_start",   72'(r_st[0][52]), 72'h1FF);
    check_eq("t2_lo_data",    r_dt[0][52],      lanes_c5);
    check_eq("t2_ov_pre",     72'(r_ov[0][63]), 72'd0);
    check_eq("t2_ov_tick",    72'(r_ov[0][64]), 72'd1);
    check_eq("t2_shoot_pre",  72'(r_sh[0][68]), 72'd0);
    check_eq("t2_shoot",      72'(r_sh[0][69]), 72'd1);
    default_cfg();

    // 3: SPI never answers
    do_reset("t3_rst");
    spi_lat[0] = 0;
    start_run();
    run(130);
    check_eq("t3_err_pre",   72'(r_te[0][95]), 72'd0);
    check_eq("t3_err",       72'(r_te[0][96]), 72'd1);
    check_eq("t3_spi_held",  72'(r_sp[0][95]), 72'd1);
    check_eq("t3_spi_drop",  72'(r_sp[0][96]), 72'd0);
    check_eq("t3_no_start",  72'(r_st[0][96]), 72'd0);
    check_eq("t3_no_shoot",  72'(cnt_sh(0, 1, 127)), 72'd0);
    check_eq("t3_next_idle", 72'(r_sp[0][127]), 72'd0);
    check_eq("t3_next_req",  72'(r_sp[0][128]), 72'd1);
    check_eq("t3_err_sticky",72'(r_te[0][130]), 72'd1);
    default_cfg();

    // 4: PERIOD=16 instance, 20-cycle busy forces overrun
    do_reset("t4_rst");
    check_eq("t4_rst_ov16", 72'(overrun[1]), 72'd0);
    start_run();
    run(85);
    check_eq("t4_req",        72'(r_sp[1][16]), 72'd1);
    check_eq("t4_ov_pre",     72'(r_ov[1][31]), 72'd0);
    check_eq("t4_ov",         72'(r_ov[1][32]), 72'd1);
    check_eq("t4_shoot",      72'(r_sh[1][63]), 72'd1);
    check_eq("t4_shoot_end",  72'(r_sh[1][67]), 72'd0);
    check_eq("t4_shoot_len",  72'(cnt_sh(1, 1, 79)), 72'd4);
    check_eq("t4_fd",         72'(r_fd[1][66]), 72'd1);
    check_eq("t4_no_req",     72'(cnt_sp(1, 20, 79)), 72'd0);
    check_eq("t4_next_req",   72'(r_sp[1][80]), 72'd1);

    // 5: reset asserted during WAIT_HI
    do_reset("t5_rst");
    start_run();
    run(40);
    check_eq("t5_mid_data",  r_dt[0][40],      lanes_ab);
    check_eq("t5_mid_start", 72'(r_st[0][40]), 72'd0);
    reset = 1'b0;
    step();
    check_zero_outputs("t5_abort");
    reset = 1'b1;
    run(40);
    check_eq("t5_no_shoot", 72'(cnt_sh(0, 41, 72)), 72'd0);
    check_eq("t5_idle",     72'(r_sp[0][72]), 72'd0);
    check_eq("t5_req",      72'(r_sp[0][73]), 72'd1);

    // 6: enable dropped during SEND_LO
    do_reset("t6_rst");
    start_run();
    run(47);
    check_eq("t6_in_send_lo", 72'(r_st[0][47]), 72'h1FF);
    enable = 1'b0;
    run(160);
    check_eq("t6_shoot",      72'(r_sh[0][59]), 72'd1);
    check_eq("t6_shoot_len",  72'(cnt_sh(0, 48, 207)), 72'd4);
    check_eq("t6_fd",         72'(cnt_fd(0, 48, 207)), 72'd1);
    check_eq("t6_no_req",     72'(cnt_sp(0, 48, 207)), 72'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
